// File: rtl/register_scoreboard_mc.sv
// register_scoreboard_mc
//   Multi-outstanding register scoreboard. Each architectural register has a
//   saturating pending-write counter, so several in-flight instructions may
//   target the same destination. Decode reserves destinations, writeback
//   retires them, and the source-query ports report operand readiness.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   flush               clear all pending counts (underflow_err untouched)
//   issue_valid/dest    destination reservation request
//   issue_ready         reservation acceptable this cycle (combinational)
//   wb_valid/dest       writeback retiring a pending write
//   src_idx             packed source indices, port k at [k*REG_IDX_W +: REG_IDX_W]
//   src_ready           per source port: operand has no pending write
//   reg_valid           per register: count == 0 (registered state only)
//   busy_any            any count nonzero
//   underflow_err       sticky: writeback hit an idle or nonexistent register
module register_scoreboard_mc #(
  parameter int NUM_REGS  = 8,
  parameter int REG_IDX_W = 3,
  parameter int CNT_W     = 2,
  parameter int NUM_SRC   = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         issue_valid,
  input  logic [REG_IDX_W-1:0]         issue_dest,
  output logic                         issue_ready,
  input  logic                         wb_valid,
  input  logic [REG_IDX_W-1:0]         wb_dest,
  input  logic [NUM_SRC*REG_IDX_W-1:0] src_idx,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic [NUM_REGS-1:0]          reg_valid,
  output logic                         busy_any,
  output logic                         underflow_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]     count [NUM_REGS];
  logic                 err_q;

  logic [CNT_W-1:0]     issue_cnt;
  logic [CNT_W-1:0]     wb_cnt;
  logic                 issue_in_range;
  logic                 wb_in_range;
  logic                 issue_fire;
  logic                 wb_fire;
  logic                 wb_bad;
  logic [NUM_REGS-1:0]  inc_vec;
  logic [NUM_REGS-1:0]  dec_vec;
  logic [REG_IDX_W-1:0] src_sel [NUM_SRC];
  logic [CNT_W-1:0]     src_cnt [NUM_SRC];
  logic                 src_in_range [NUM_SRC];

  // Current counts for the issue, writeback and source indices. Indices that
  // do not name a tracked register read back as zero and are flagged
  // out-of-range separately.
  always_comb begin
    issue_in_range = (32'(issue_dest) < NUM_REGS);
    wb_in_range    = (32'(wb_dest) < NUM_REGS);
    issue_cnt      = '0;
    wb_cnt         = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (issue_dest == REG_IDX_W'(r)) issue_cnt = count[r];
      if (wb_dest == REG_IDX_W'(r))    wb_cnt    = count[r];
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      src_sel[k]      = src_idx[k*REG_IDX_W +: REG_IDX_W];
      src_in_range[k] = (32'(src_sel[k]) < NUM_REGS);
      src_cnt[k]      = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (src_sel[k] == REG_IDX_W'(r)) src_cnt[k] = count[r];
      end
    end
  end

  // A full counter can still accept an issue when the same register retires
  // in this cycle, because the pair leaves the count unchanged.
  always_comb begin
    issue_ready = issue_in_range &
                  ((issue_cnt != CNT_MAX) |
                   (wb_valid & (wb_dest == issue_dest) & (issue_cnt != '0)));
    issue_fire  = issue_valid & issue_ready;
    wb_fire     = wb_valid & wb_in_range & (wb_cnt != '0);
    wb_bad      = wb_valid & (~wb_in_range | (wb_cnt == '0));
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = issue_fire & (issue_dest == REG_IDX_W'(r));
      dec_vec[r] = wb_fire & (wb_dest == REG_IDX_W'(r));
    end
  end

  // Bypass: the last pending write retiring now makes the operand ready in
  // this cycle, unless a new reservation on the same register lands at once.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      src_ready[k] = ~src_in_range[k] | (src_cnt[k] == '0) |
                     ((WB_BYPASS != 0) & (src_cnt[k] == CNT_ONE) & wb_fire &
                      (wb_dest == src_sel[k]) &
                      ~(issue_fire & (issue_dest == src_sel[k])));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) count[r] <= '0;
      err_q <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) count[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] & ~dec_vec[r])      count[r] <= count[r] + CNT_ONE;
        else if (dec_vec[r] & ~inc_vec[r]) count[r] <= count[r] - CNT_ONE;
      end
      if (wb_bad) err_q <= 1'b1;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) reg_valid[r] = (count[r] == '0);
  end

  assign busy_any      = ~&reg_valid;
  assign underflow_err = err_q;

endmodule
